axis_pixel_pipe: RTL and testbench

AXIS_PIXEL_PIPE -- requirements
Module: axis_pixel_pipe

---
 rtl/axis_pixel_pipe.sv | 132 +++++++++++++
 tb/tb_axis_pixel_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pixel_pipe.sv
// axis_pixel_pipe: AXI-Stream pixel processor.
// An input capture stage feeds a fixed-latency, non-stalling arithmetic pipe
// (bypass / invert / Q4.4 gain with saturation). The pipe drains into a
// first-word-fall-through output FIFO. Credit-based input flow control keeps
// the FIFO from ever overflowing.
module axis_pixel_pipe #(
    parameter int CH    = 3,
    parameter int DW    = 8,
    parameter int LAT   = 3,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [7:0]              gain,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [CH*DW-1:0]        s_axis_tdata,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [CH*DW-1:0]        m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    localparam int W  = CH * DW;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        MODE_BYP  = 2'b00,
        MODE_INV  = 2'b01,
        MODE_GAIN = 2'b10,
        MODE_BYP2 = 2'b11
    } mode_e;

    // Stage 0 holds the raw accepted beat; stages 1..LAT hold processed data.
    logic [LAT:0]    r_vld;
    logic [LAT:0]    r_last;
    logic [W-1:0]    r_data [0:LAT];
    mode_e           r_mode;
    logic [7:0]      r_gain;

    logic [W-1:0]    w_proc;
    logic [DW-1:0]   w_x;
    logic [DW+7:0]   w_scaled;
    logic [31:0]     w_inflight;

    logic [W:0]      r_mem [0:DEPTH-1];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;

    logic            w_accept;
    logic            w_push;
    logic            w_pop;

    // Credit: every beat in the pipe already owns a FIFO slot, so accept only
    // while pipe occupancy plus FIFO occupancy leaves room.
    assign s_axis_tready = !rst && ((w_inflight + 32'(r_level)) < 32'(DEPTH));
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_push        = r_vld[LAT];
    assign w_pop         = m_axis_tvalid & m_axis_tready;

    assign m_axis_tvalid                = !rst && (r_level != '0);
    assign {m_axis_tlast, m_axis_tdata} = r_mem[r_rptr];
    assign fifo_level                   = r_level;

    // Count of valid stages currently travelling through the pipe.
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i <= LAT; i++) begin
            w_inflight = w_inflight + 32'(r_vld[i]);
        end
    end

    // Per-channel arithmetic on the captured beat, using its own mode/gain.
    always_comb begin
        w_proc   = '0;
        w_x      = '0;
        w_scaled = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            w_x      = r_data[0][c*DW +: DW];
            w_scaled = ((DW+8)'(w_x) * (DW+8)'(r_gain) + (DW+8)'(8)) >> 4;
            case (r_mode)
                MODE_INV:  w_proc[c*DW +: DW] = ~w_x;
                MODE_GAIN: w_proc[c*DW +: DW] = (|w_scaled[DW+7:DW]) ? '1 : w_scaled[DW-1:0];
                default:   w_proc[c*DW +: DW] = w_x;
            endcase
        end
    end

    // Control state: stage valid shift register, FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_vld <= {r_vld[LAT-1:0], w_accept};
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // Datapath: capture, unconditional stage shift, and FIFO storage write.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data[0] <= s_axis_tdata;
            r_last[0] <= s_axis_tlast;
            r_mode    <= mode_e'(mode);
            r_gain    <= gain;
        end
        r_data[1] <= w_proc;
        r_last[1] <= r_last[0];
        for (int unsigned i = 2; i <= LAT; i++) begin
            r_data[i] <= r_data[i-1];
            r_last[i] <= r_last[i-1];
        end
        if (w_push) begin
            r_mem[r_wptr] <= {r_last[LAT], r_data[LAT]};
        end
    end

endmodule

// File: tb/tb_axis_pixel_pipe.sv
// tb_axis_pixel_pipe: directed and randomized checks of axis_pixel_pipe
// against a transaction-level reference (queue of outstanding beats with
// their acceptance edge).
module tb_axis_pixel_pipe;

    localparam int CH    = 3;
    localparam int DW    = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  gain;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [23:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [3:0]  fifo_level;

    axis_pixel_pipe #(.CH(CH), .DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .gain          (gain),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned acc_e;
        logic [24:0] beat;
    } ent_t;

    ent_t        q[$];
    int unsigned cyc   = 0;
    bit          known = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_pix(input logic [1:0] md, input logic [7:0] g,
                                            input logic [23:0] px);
        logic [23:0] r;
        int unsigned c;
        int unsigned v;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            c = 32'(px[k*8 +: 8]);
            case (md)
                2'b01: v = 255 - c;
                2'b10: begin
                    v = (c * 32'(g) + 8) / 16;
                    if (v > 255) v = 255;
                end
                default: v = c;
            endcase
            r[k*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    // One clock cycle: check outputs against the model, then advance both.
    task automatic tick(output bit acc);
        bit          exp_rdy;
        bit          exp_vld;
        bit          pop;
        int unsigned vis;
        #1;
        vis = 0;
        foreach (q[i]) if (cyc >= q[i].acc_e + LAT + 2) vis++;
        exp_rdy = !rst && (q.size() < DEPTH);
        exp_vld = !rst && (vis != 0);
        chk("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
        chk("m_tvalid", 32'(m_axis_tvalid), 32'(exp_vld));
        if (known) chk("fifo_level", 32'(fifo_level), vis);
        if (exp_vld) chk("m_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(q[0].beat));
        acc = s_axis_tvalid && exp_rdy;
        pop = exp_vld && m_axis_tready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            known = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{acc_e: cyc,
                                   beat: {s_axis_tlast, ref_pix(mode, gain, s_axis_tdata)}});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        bit a;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (14) tick(a);
    endtask

    // Single beat on an idle pipe: check latency, value and that it leaves.
    task automatic directed(input string tag, input logic [1:0] md, input logic [7:0] g,
                            input logic [23:0] px, input logic lst,
                            input logic [23:0] exp_px);
        bit a;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        mode = md; gain = g; s_axis_tdata = px; s_axis_tlast = lst;
        tick(a);
        chk({tag, "_acc"}, 32'(a), 32'd1);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(a);
            chk({tag, "_early"}, 32'(m_axis_tvalid), 32'd0);
        end
        tick(a);
        chk({tag, "_vld"},  32'(m_axis_tvalid), 32'd1);
        chk({tag, "_data"}, 32'(m_axis_tdata), 32'(exp_px));
        chk({tag, "_last"}, 32'(m_axis_tlast), 32'(lst));
        tick(a);
        chk({tag, "_gone"}, 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        bit a;
        int n;
        rst = 1'b1; mode = 2'b00; gain = 8'h10;
        s_axis_tvalid = 1'b1; s_axis_tdata = 24'h123456; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);

        // Reset held for two cycles with input offered
        tick(a);
        tick(a);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        chk("rst_release_rdy", 32'(s_axis_tready), 32'd1);
        drain();

        directed("bypass", 2'b00, 8'h00, 24'h102030, 1'b0, 24'h102030);
        directed("gain",   2'b10, 8'h18, 24'hC81000, 1'b0, 24'hFF1800);
        directed("invert", 2'b01, 8'h00, 24'h00FF7F, 1'b1, 24'hFF0080);
        directed("byp11",  2'b11, 8'hFF, 24'hA5_5A_01, 1'b1, 24'hA55A01);
        drain();

        // Backpressure: credit limit then in-order burst release
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1; mode = 2'b00; s_axis_tlast = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            s_axis_tdata = 24'(n + 1);
            tick(a);
            if (a) n++;
        end
        chk("bp_count", 32'(n), 32'd8);
        chk("bp_tready", 32'(s_axis_tready), 32'd0);
        chk("bp_full", 32'(fifo_level), 32'd8);
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_vld", 32'(m_axis_tvalid), 32'd1);
            chk("bp_order", 32'(m_axis_tdata), 32'(i + 1));
            tick(a);
        end
        chk("bp_empty", 32'(m_axis_tvalid), 32'd0);
        drain();

        // Mid-stream reset discards everything accepted before it
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_axis_tdata = 24'(32'hA0 + i);
            tick(a);
            chk("mr_acc", 32'(a), 32'd1);
        end
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        tick(a);
        rst = 1'b0;
        chk("mr_level", 32'(fifo_level), 32'd0);
        chk("mr_mvalid", 32'(m_axis_tvalid), 32'd0);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(a);
            chk("mr_no_stale", 32'(m_axis_tvalid), 32'd0);
        end

        // Randomized traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            m_axis_tready = (i % 200 < 100) ? ($urandom_range(0, 4) != 0)
                                            : ($urandom_range(0, 2) == 0);
            mode          = 2'($urandom_range(0, 3));
            gain          = 8'($urandom);
            s_axis_tdata  = 24'($urandom);
            s_axis_tlast  = 1'($urandom);
            tick(a);
        end
        rst = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
